// File: rtl/frame_stream_tx.sv
// frame_stream_tx: sends one kernel-select word on m1, then streams FRAME_WORDS
// words from a synchronous-read memory onto m0 (last on the final word).
// A 2-entry output FIFO plus a one-deep read credit hides the memory latency so
// the pixel stream sustains one word per cycle under arbitrary backpressure.
module frame_stream_tx #(
    parameter int DATA_WIDTH  = 32,
    parameter int NB_ADDR     = 10,
    parameter int FRAME_WORDS = 200
) (
    input  logic                  axi_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [1:0]            i_kernel_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_en,
    output logic [NB_ADDR-1:0]    o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  m0_axis_valid,
    output logic [DATA_WIDTH-1:0] m0_axis_data,
    output logic                  m0_axis_last,
    input  logic                  m0_axis_ready,
    output logic                  m1_axis_valid,
    output logic [DATA_WIDTH-1:0] m1_axis_data,
    input  logic                  m1_axis_ready
);

    // One extra bit so FRAME_WORDS == 2^NB_ADDR is representable as an end marker.
    localparam int CNT_W = NB_ADDR + 1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KSEL,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]            ksel_reg;
    logic [CNT_W-1:0]      rd_addr_reg;
    logic                  inflight_reg;
    logic                  inflight_last_reg;

    logic [DATA_WIDTH-1:0] fifo_data_reg [0:1];
    logic                  fifo_last_reg [0:1];
    logic                  head_reg;
    logic                  tail_reg;
    logic [1:0]            fifo_count_reg;

    logic                  push;
    logic                  pop;
    logic                  issue_ok;
    logic [2:0]            occupancy;
    logic                  head_last;

    assign m0_axis_valid = (fifo_count_reg != 2'd0);
    assign head_last     = fifo_last_reg[head_reg];
    assign m0_axis_data  = m0_axis_valid ? fifo_data_reg[head_reg] : '0;
    assign m0_axis_last  = m0_axis_valid & head_last;

    assign pop  = m0_axis_valid & m0_axis_ready;
    assign push = inflight_reg;

    // Words already buffered or on their way; a new read is allowed only if the
    // FIFO is guaranteed a free slot when its data arrives next cycle.
    assign occupancy = {1'b0, fifo_count_reg} + {2'b00, inflight_reg};
    assign issue_ok  = occupancy < (3'd2 + {2'b00, pop});

    assign o_mem_en   = (state_reg == ST_STREAM) && (rd_addr_reg < FRAME_CNT) && issue_ok;
    assign o_mem_addr = rd_addr_reg[NB_ADDR-1:0];

    // State register.
    always_ff @(posedge axi_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next    = state_reg;
        o_busy        = 1'b1;
        o_done        = 1'b0;
        m1_axis_valid = 1'b0;
        m1_axis_data  = '0;
        case (state_reg)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_next = ST_KSEL;
                end
            end
            ST_KSEL: begin
                m1_axis_valid = 1'b1;
                m1_axis_data  = {{(DATA_WIDTH-2){1'b0}}, ksel_reg};
                if (m1_axis_ready) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pop && head_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame setup, read address generation and the one-deep in-flight tracker.
    always_ff @(posedge axi_clk) begin
        if (i_rst) begin
            ksel_reg          <= 2'd0;
            rd_addr_reg       <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && i_start) begin
                ksel_reg    <= i_kernel_sel;
                rd_addr_reg <= '0;
            end else if (o_mem_en) begin
                rd_addr_reg <= rd_addr_reg + 1'b1;
            end
            inflight_reg      <= o_mem_en;
            inflight_last_reg <= (rd_addr_reg == LAST_IDX);
        end
    end

    // Two-entry output FIFO; returning read data is written at the tail with its last tag.
    always_ff @(posedge axi_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_last_reg[i] <= 1'b0;
            end
            head_reg       <= 1'b0;
            tail_reg       <= 1'b0;
            fifo_count_reg <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_reg[tail_reg] <= i_mem_data;
                fifo_last_reg[tail_reg] <= inflight_last_reg;
                tail_reg                <= ~tail_reg;
            end
            if (pop) begin
                head_reg <= ~head_reg;
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 2'd1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 2'd1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stream_tx.sv
// Scoreboard bench for frame_stream_tx: an 8-word instance and a 1-word instance.
module tb_frame_stream_tx;

    localparam int DW = 32;
    localparam int AW = 10;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic rst;

    logic          start8, start1;
    logic [1:0]    ksel8, ksel1;
    logic          busy8, done8, mem_en8, busy1, done1, mem_en1;
    logic [AW-1:0] mem_addr8, mem_addr1;
    logic [DW-1:0] mem_data8, mem_data1;
    logic          m0v8, m0l8, m0r8, m1v8, m1r8;
    logic          m0v1, m0l1, m0r1, m1v1, m1r1;
    logic [DW-1:0] m0d8, m1d8, m0d1, m1d1;

    frame_stream_tx #(.DATA_WIDTH(DW), .NB_ADDR(AW), .FRAME_WORDS(8)) dut8 (
        .axi_clk(clk), .i_rst(rst), .i_start(start8), .i_kernel_sel(ksel8),
        .o_busy(busy8), .o_done(done8), .o_mem_en(mem_en8), .o_mem_addr(mem_addr8),
        .i_mem_data(mem_data8),
        .m0_axis_valid(m0v8), .m0_axis_data(m0d8), .m0_axis_last(m0l8), .m0_axis_ready(m0r8),
        .m1_axis_valid(m1v8), .m1_axis_data(m1d8), .m1_axis_ready(m1r8)
    );

    frame_stream_tx #(.DATA_WIDTH(DW), .NB_ADDR(AW), .FRAME_WORDS(1)) dut1 (
        .axi_clk(clk), .i_rst(rst), .i_start(start1), .i_kernel_sel(ksel1),
        .o_busy(busy1), .o_done(done1), .o_mem_en(mem_en1), .o_mem_addr(mem_addr1),
        .i_mem_data(mem_data1),
        .m0_axis_valid(m0v1), .m0_axis_data(m0d1), .m0_axis_last(m0l1), .m0_axis_ready(m0r1),
        .m1_axis_valid(m1v1), .m1_axis_data(m1d1), .m1_axis_ready(m1r1)
    );

    // Synchronous-read memories: word[i] = i + 0x100.
    always @(posedge clk) if (mem_en8) mem_data8 <= 32'h100 + 32'(mem_addr8);
    always @(posedge clk) if (mem_en1) mem_data1 <= 32'h100 + 32'(mem_addr1);

    exp_t exp_m0_8[$], exp_m1_8[$], exp_m0_1[$], exp_m1_1[$];
    int   exp_done_8[$], exp_done_1[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string msg);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endfunction

    // Monitor for the 8-word instance: scoreboard pops, stability and safety checks.
    int          hs8 = 0, done_cnt8 = 0;
    logic        prev_stall8 = 0, prev_kstall8 = 0, prev_l8 = 0;
    logic [DW-1:0] prev_d8 = '0, prev_k8 = '0;
    always @(negedge clk) begin
        exp_t e;
        int   ec;
        if (rst) begin
            prev_stall8  = 0;
            prev_kstall8 = 0;
        end else begin
            if (prev_stall8) begin
                check("m0_8 valid held in stall", m0v8, 1);
                check("m0_8 data stable in stall", m0d8, prev_d8);
                check("m0_8 last stable in stall", m0l8, prev_l8);
            end
            if (prev_kstall8) begin
                check("m1_8 valid held in stall", m1v8, 1);
                check("m1_8 data stable in stall", m1d8, prev_k8);
            end
            if (m0v8 && m0r8) begin
                if (exp_m0_8.size() == 0) fail($sformatf("m0_8 unexpected word 0x%0h", m0d8));
                else begin
                    e = exp_m0_8.pop_front();
                    check("m0_8 data", m0d8, e.data);
                    check("m0_8 last", m0l8, e.last);
                    if (e.cyc >= 0) check("m0_8 cycle", cyc, e.cyc);
                end
                hs8++;
            end
            if (m1v8) check("mem_en8 low during kernel word", mem_en8, 0);
            if (m1v8 && m1r8) begin
                if (exp_m1_8.size() == 0) fail($sformatf("m1_8 unexpected word 0x%0h", m1d8));
                else begin
                    e = exp_m1_8.pop_front();
                    check("m1_8 data", m1d8, e.data);
                    check("m1_8 cycle", cyc, e.cyc);
                end
            end
            if (mem_en8) check("mem_addr8 below FRAME_WORDS", mem_addr8 < 8, 1);
            check("fifo8 occupancy <= 2", dut8.fifo_count_reg <= 2, 1);
            if (done8) begin
                if (exp_done_8.size() == 0) fail("done8 unexpected pulse");
                else begin
                    ec = exp_done_8.pop_front();
                    if (ec >= 0) check("done8 cycle", cyc, ec);
                end
                done_cnt8++;
            end
            prev_stall8  = m0v8 && !m0r8;
            prev_kstall8 = m1v8 && !m1r8;
            prev_d8 = m0d8;
            prev_l8 = m0l8;
            prev_k8 = m1d8;
        end
    end

    // Monitor for the 1-word instance.
    int done_cnt1 = 0;
    always @(negedge clk) begin
        exp_t e;
        int   ec;
        if (!rst) begin
            if (m0v1 && m0r1) begin
                if (exp_m0_1.size() == 0) fail($sformatf("m0_1 unexpected word 0x%0h", m0d1));
                else begin
                    e = exp_m0_1.pop_front();
                    check("m0_1 data", m0d1, e.data);
                    check("m0_1 last", m0l1, e.last);
                    check("m0_1 cycle", cyc, e.cyc);
                end
            end
            if (m1v1 && m1r1) begin
                if (exp_m1_1.size() == 0) fail("m1_1 unexpected word");
                else begin
                    e = exp_m1_1.pop_front();
                    check("m1_1 data", m1d1, e.data);
                    check("m1_1 cycle", cyc, e.cyc);
                end
            end
            if (mem_en1) check("mem_addr1 below FRAME_WORDS", mem_addr1 < 1, 1);
            if (done1) begin
                if (exp_done_1.size() == 0) fail("done1 unexpected pulse");
                else begin
                    ec = exp_done_1.pop_front();
                    check("done1 cycle", cyc, ec);
                end
                done_cnt1++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a start on the 8-word instance and queue its expected response.
    task automatic frame8(input logic [1:0] sel, input bit timed, input int kstall);
        int s;
        s = cyc;
        start8 = 1;
        ksel8  = sel;
        exp_m1_8.push_back('{data: {30'd0, sel}, last: 1'b0, cyc: s + 1 + kstall});
        for (int i = 0; i < 8; i++)
            exp_m0_8.push_back('{data: 32'h100 + 32'(i), last: (i == 7), cyc: timed ? s + 4 + kstall + i : -1});
        exp_done_8.push_back(timed ? s + 12 + kstall : -1);
        tick();
        start8 = 0;
    endtask

    task automatic wait_done8(input int d0, input string what);
        int k;
        k = 0;
        while (done_cnt8 == d0 && k < 200) begin
            tick();
            k++;
        end
        if (done_cnt8 == d0) fail({"timeout waiting for done8 in ", what});
    endtask

    task automatic check_outputs_zero8();
        check("rst busy8", busy8, 0);
        check("rst done8", done8, 0);
        check("rst mem_en8", mem_en8, 0);
        check("rst mem_addr8", mem_addr8, 0);
        check("rst m0_valid8", m0v8, 0);
        check("rst m0_data8", m0d8, 0);
        check("rst m0_last8", m0l8, 0);
        check("rst m1_valid8", m1v8, 0);
        check("rst m1_data8", m1d8, 0);
    endtask

    initial begin
        int d0, h0, k, s;
        rst = 1;
        start8 = 0; ksel8 = 0; m0r8 = 1; m1r8 = 1;
        start1 = 0; ksel1 = 0; m0r1 = 1; m1r1 = 1;
        tick(3);
        check_outputs_zero8();
        check("rst m0_valid1", m0v1, 0);
        check("rst m1_valid1", m1v1, 0);
        check("rst busy1", busy1, 0);
        rst = 0;
        tick();

        // Nominal frame, then an immediate back-to-back start in the first IDLE cycle.
        d0 = done_cnt8;
        frame8(2'd2, 1, 0);
        wait_done8(d0, "nominal");
        d0 = done_cnt8;
        frame8(2'd0, 1, 0);
        wait_done8(d0, "back-to-back");
        tick(2);

        // Backpressure: ready follows 1-0-0-1.
        d0 = done_cnt8;
        frame8(2'd2, 0, 0);
        k = 0;
        while (done_cnt8 == d0 && k < 200) begin
            m0r8 = (k % 4 == 0) || (k % 4 == 3);
            tick();
            k++;
        end
        if (done_cnt8 == d0) fail("timeout waiting for done8 in backpressure");
        m0r8 = 1;
        tick(2);

        // Kernel stall: m1 ready low for 5 cycles after start.
        d0 = done_cnt8;
        m1r8 = 0;
        frame8(2'd3, 1, 5);
        tick(5);
        m1r8 = 1;
        wait_done8(d0, "kernel stall");
        tick(2);

        // Second start and new select during STREAM must be ignored.
        d0 = done_cnt8;
        frame8(2'd2, 1, 0);
        tick(5);
        start8 = 1;
        ksel8  = 2'd1;
        tick();
        start8 = 0;
        wait_done8(d0, "ignored start");
        tick(6);
        check("single done for ignored start", done_cnt8, d0 + 1);
        d0 = done_cnt8;
        frame8(2'd1, 1, 0);
        wait_done8(d0, "select 1 frame");
        tick(2);

        // Reset after three pixel handshakes, then replay the frame.
        h0 = hs8;
        frame8(2'd3, 1, 0);
        k = 0;
        while (hs8 < h0 + 3 && k < 200) begin
            tick();
            k++;
        end
        if (hs8 < h0 + 3) fail("timeout waiting for 3 handshakes");
        m0r8 = 0;
        rst  = 1;
        exp_m0_8.delete();
        exp_done_8.delete();
        tick();
        check_outputs_zero8();
        rst  = 0;
        m0r8 = 1;
        tick();
        d0 = done_cnt8;
        frame8(2'd2, 1, 0);
        wait_done8(d0, "replay after reset");
        tick(2);

        // Single-word frame.
        d0 = done_cnt1;
        s = cyc;
        start1 = 1;
        ksel1  = 2'd2;
        exp_m1_1.push_back('{data: 32'd2, last: 1'b0, cyc: s + 1});
        exp_m0_1.push_back('{data: 32'h100, last: 1'b1, cyc: s + 4});
        exp_done_1.push_back(s + 5);
        tick();
        start1 = 0;
        k = 0;
        while (done_cnt1 == d0 && k < 50) begin
            tick();
            k++;
        end
        if (done_cnt1 == d0) fail("timeout waiting for done1");
        tick(3);

        check("m0_8 scoreboard drained", exp_m0_8.size(), 0);
        check("m1_8 scoreboard drained", exp_m1_8.size(), 0);
        check("done8 scoreboard drained", exp_done_8.size(), 0);
        check("m0_1 scoreboard drained", exp_m0_1.size(), 0);
        check("done1 scoreboard drained", exp_done_1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/frame_stream_tx.md
# frame_stream_tx

Frame transmitter that feeds the stream convolver from a synchronous-read frame memory. On a start pulse it sends one kernel-select word on the kernel stream (m1), then reads FRAME_WORDS words from memory and emits them on the pixel stream (m0), with `last` on the final word. A 2-entry output FIFO and read-credit logic absorb the 1-cycle memory latency, so the block sustains one word per cycle under full backpressure tolerance.

## Interface

Parameters:
- DATA_WIDTH, 32, stream word and memory data width
- NB_ADDR, 10, memory address width
- FRAME_WORDS, 200, words per frame; must satisfy 1 <= FRAME_WORDS <= 2^NB_ADDR

Ports:
- axi_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_start  in  1  start-frame pulse; sampled only in IDLE
- i_kernel_sel  in  2  kernel select; latched when i_start is accepted
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the last m0 word handshakes
- o_mem_en  out  1  memory read enable (combinational from state/credit)
- o_mem_addr  out  NB_ADDR  read address, valid while o_mem_en is high
- i_mem_data  in  DATA_WIDTH  read data, valid the cycle after o_mem_en
- m0_axis_valid / m0_axis_data / m0_axis_last  out  1 / DATA_WIDTH / 1  pixel stream master
- m0_axis_ready  in  1
- m1_axis_valid / m1_axis_data  out  1 / DATA_WIDTH  kernel-select stream master
- m1_axis_ready  in  1

## Operation

- FSM states: IDLE, KSEL, STREAM, DONE.
- IDLE: when i_start=1, latch i_kernel_sel, clear the read address and word counters, and go to KSEL. When i_start=0, stay in IDLE.
- KSEL:
  - m1_axis_valid=1 and m1_axis_data={zeros, ksel_latched}.
  - Hold both until m1_axis_ready=1.
  - The handshake cycle moves the FSM to STREAM.
- STREAM read issue:
  - o_mem_en=1 when rd_addr < FRAME_WORDS and fifo_count + inflight - pop < 2.
  - pop = m0_axis_valid & m0_axis_ready.
  - o_mem_addr = rd_addr; rd_addr increments on each issue.
- inflight is a 1-bit register, set to o_mem_en on each edge.
- When inflight=1, i_mem_data is written to the FIFO tail together with tag last = (that word's index == FRAME_WORDS-1).
- m0 outputs:
  - m0_axis_valid = (fifo_count != 0).
  - m0_axis_data and m0_axis_last come from the FIFO head.
  - Data and last remain stable while valid=1 and ready=0.
- STREAM -> DONE on the handshake of the word with last=1.
- DONE lasts one cycle: o_done=1, then the FSM returns to IDLE.
- Simultaneous FIFO push and pop in the same cycle: fifo_count is unchanged and order is preserved.
- The FIFO never overflows; credit logic guarantees fifo_count <= 2. An overflow is a design bug and is covered by a bench assertion.
- No memory read is ever issued for an address >= FRAME_WORDS.
- i_start is ignored in KSEL, STREAM and DONE.
- i_kernel_sel changes after acceptance have no effect on the current frame.
- FRAME_WORDS=1: a single word, with m0_axis_last=1 on it.
- Reset:
  - Takes effect in any state, including mid-frame.
  - Returns the FSM to IDLE and flushes the FIFO, inflight and counters.
  - Reset values: all outputs 0, namely o_busy, o_done, o_mem_en, o_mem_addr, m0_axis_valid, m0_axis_data, m0_axis_last, m1_axis_valid, m1_axis_data.

## Timing

- Start accepted in cycle 0; KSEL in cycle 1 with m1_axis_valid=1.
- With m1_axis_ready=1, STREAM begins in cycle 2 and the first read (address 0) issues in cycle 2.
- Data arrives in cycle 3 and is pushed at the end of cycle 3; m0_axis_valid=1 from cycle 4.
- With m0_axis_ready held at 1, one word per cycle is sent. The last word handshakes in cycle 3+FRAME_WORDS, o_done=1 in cycle 4+FRAME_WORDS, and the FSM is in IDLE in cycle 5+FRAME_WORDS.
- A m0_axis_ready stall of any length loses no words, and at most 2 words are buffered. After ready returns, the throughput of 1 word/cycle resumes without a bubble.
- A new i_start is accepted in the first IDLE cycle after DONE.

## Test plan

- Nominal: FRAME_WORDS=8, memory word[i]=i+0x100, ksel=2, both readies held at 1.
  - m1 word 0x00000002 in cycle 1.
  - m0 words 0x100..0x107 in cycles 4..11, with last only on 0x107.
  - o_done pulse in cycle 12.
- Backpressure: same frame with m0_axis_ready toggled in a 1-0-0-1 pattern.
  - All 8 words arrive in order with no duplicates.
  - Data is stable during stalls and fifo_count never exceeds 2.
  - No o_mem_addr >= 8 is issued.
- Kernel stall: m1_axis_ready held at 0 for 5 cycles after start.
  - m1_axis_valid stays 1 with constant data.
  - o_mem_en stays 0 until the handshake; stream timing then shifts by 5 cycles.
- Ignored start and latch: i_start pulsed again mid-STREAM and i_kernel_sel changed to 1.
  - Exactly one frame is sent and one o_done pulse occurs.
  - The next frame's m1 word is 0x00000001.
- Reset mid-frame: i_rst asserted after 3 of 8 m0 handshakes.
  - All outputs are 0 the next cycle.
  - A subsequent start replays the frame from address 0 with correct last placement.
- FRAME_WORDS=1 with readies held at 1: a single m0 word with last=1 in cycle 4, and o_done in cycle 5.
